// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: debounces the external request, qualifies PLL lock,
// then releases NCH active-low channel resets in index order, spaced by GAP_CYCLES.
module reset_seq #(
  parameter int NCH         = 3,
  parameter int DEB_CYCLES  = 1000,
  parameter int LOCK_CYCLES = 256,
  parameter int GAP_CYCLES  = 16,
  parameter int MIN_HOLD    = 64,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rst_req_n,
  input  logic           pll_lock,
  input  logic           soft_rst,
  output logic [NCH-1:0] ch_reset_n,
  output logic           seq_done,
  output logic           pll_lock_n,
  output logic [7:0]     lock_loss_cnt,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {S_HOLD, S_WAIT_LOCK, S_STAGE, S_RUN} state_e;

  localparam int IDX_W = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

  logic             rq_s1_q, rq_s_q, lk_s1_q, lk_s_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d, lock_q, lock_d, gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NCH-1:0]   ch_q, ch_d;
  logic             done_q, done_d, lkn_q;
  logic [7:0]       llc_q, llc_d;
  logic             lock_lost, abort;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      rq_s1_q <= 1'b0; rq_s_q <= 1'b0; lk_s1_q <= 1'b0; lk_s_q <= 1'b0;
      deb_q   <= 1'b0; deb_cnt_q <= '0;
      state_q <= S_HOLD;
      hold_q  <= '0; lock_q <= '0; gap_q <= '0; idx_q <= '0;
      ch_q    <= '0; done_q <= 1'b0; lkn_q <= 1'b1; llc_q <= '0;
    end else begin
      rq_s1_q <= rst_req_n; rq_s_q <= rq_s1_q;
      lk_s1_q <= pll_lock;  lk_s_q <= lk_s1_q;
      deb_q   <= deb_d; deb_cnt_q <= deb_cnt_d;
      state_q <= state_d;
      hold_q  <= hold_d; lock_q <= lock_d; gap_q <= gap_d; idx_q <= idx_d;
      ch_q    <= ch_d; done_q <= done_d; lkn_q <= ~lk_s_q; llc_q <= llc_d;
    end
  end

  assign lock_lost = ~lk_s_q & ((state_q == S_STAGE) | (state_q == S_RUN));
  assign abort     = ~deb_q | soft_rst | lock_lost;

  // Next-state logic
  always_comb begin
    deb_d = deb_q; deb_cnt_d = '0;
    state_d = state_q;
    hold_d = hold_q; lock_d = lock_q; gap_d = gap_q; idx_d = idx_q;
    ch_d = ch_q; done_d = done_q; llc_d = llc_q;

    if (rq_s_q != deb_q) begin
      if (deb_cnt_q == DEB_MAX) deb_d = rq_s_q;
      else                      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    if (abort) begin
      state_d = S_HOLD;
      ch_d    = '0;
      done_d  = 1'b0;
      // A held-low request while already in HOLD keeps the minimum-hold timer running
      if (state_q != S_HOLD || soft_rst) hold_d = '0;
      else if (hold_q != HOLD_MAX)       hold_d = hold_q + 1'b1;
      if (lock_lost && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
          else begin
            state_d = S_WAIT_LOCK;
            lock_d  = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (!lk_s_q)                lock_d = '0;
          else if (lock_q != LOCK_MAX) lock_d = lock_q + 1'b1;
          else begin
            ch_d  = NCH'(1);
            idx_d = IDX_W'(1);
            gap_d = '0;
            if (NCH == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_STAGE;
            end
          end
        end
        S_STAGE: begin
          if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
          else begin
            ch_d  = ch_q | (NCH'(1) << idx_q);
            idx_d = idx_q + 1'b1;
            gap_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are straight from registers
  always_comb begin
    ch_reset_n    = ch_q;
    seq_done      = done_q;
    pll_lock_n    = lkn_q;
    lock_loss_cnt = llc_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: NCH=3 sequencing/abort cases and an NCH=1 saturation run.
module tb_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rst_req_n, pll_lock, soft_rst;
  logic [2:0] ch;
  logic       done, lkn;
  logic [7:0] llc;
  logic [1:0] st;

  logic       reset1, rst_req_n1, pll_lock1, soft_rst1;
  logic [0:0] ch1;
  logic       done1, lkn1;
  logic [7:0] llc1;
  logic [1:0] st1;

  int total = 0;
  int bad   = 0;

  reset_seq #(.NCH(3), .DEB_CYCLES(4), .LOCK_CYCLES(8), .GAP_CYCLES(3), .MIN_HOLD(5), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .rst_req_n(rst_req_n), .pll_lock(pll_lock), .soft_rst(soft_rst),
    .ch_reset_n(ch), .seq_done(done), .pll_lock_n(lkn), .lock_loss_cnt(llc), .state(st));

  reset_seq #(.NCH(1), .DEB_CYCLES(4), .LOCK_CYCLES(8), .GAP_CYCLES(3), .MIN_HOLD(5), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset1), .rst_req_n(rst_req_n1), .pll_lock(pll_lock1), .soft_rst(soft_rst1),
    .ch_reset_n(ch1), .seq_done(done1), .pll_lock_n(lkn1), .lock_loss_cnt(llc1), .state(st1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rst_req_n = 1'b1; pll_lock = 1'b1; soft_rst = 1'b0;
    reset1 = 1'b1; rst_req_n1 = 1'b1; pll_lock1 = 1'b1; soft_rst1 = 1'b0;
    step(2);
    chk("rst_state", st, 0);
    chk("rst_ch", ch, 3'b000);
    chk("rst_done", done, 0);
    chk("rst_lkn", lkn, 1);
    chk("rst_llc", llc, 0);

    // Power-up: edge 1 is the first edge with reset low
    reset = 1'b0;
    step(2);  chk("pu_lkn_e2", lkn, 1);
    step(1);  chk("pu_lkn_e3", lkn, 0);
    step(3);  chk("pu_hold_e6", st, 0);
    step(1);  chk("pu_wait_e7", st, 1);
    step(7);  chk("pu_ch_e14", ch, 3'b000);
    step(1);  chk("pu_ch_e15", ch, 3'b001);
              chk("pu_st_e15", st, 2);
    step(2);  chk("pu_ch_e17", ch, 3'b001);
    step(1);  chk("pu_ch_e18", ch, 3'b011);
    step(2);  chk("pu_done_e20", done, 0);
    step(1);  chk("pu_ch_e21", ch, 3'b111);
              chk("pu_done_e21", done, 1);
              chk("pu_run_e21", st, 3);

    // One-cycle lock drop in RUN
    pll_lock = 1'b0;
    step(1);  pll_lock = 1'b1;
    step(1);  chk("ll_ch_e23", ch, 3'b111);
    step(1);  chk("ll_ch_e24", ch, 3'b000);
              chk("ll_done_e24", done, 0);
              chk("ll_llc_e24", llc, 1);
              chk("ll_st_e24", st, 0);
    step(4);  chk("ll_hold_e28", st, 0);
    step(1);  chk("ll_wait_e29", st, 1);
    step(7);  chk("ll_ch_e36", ch, 3'b000);
    step(1);  chk("ll_ch_e37", ch, 3'b001);

    // soft_rst on the edge that would release ch1
    step(2);  soft_rst = 1'b1;
    step(1);  soft_rst = 1'b0;
              chk("sr_ch_e40", ch, 3'b000);
              chk("sr_st_e40", st, 0);
              chk("sr_llc_e40", llc, 1);
    step(2);  chk("sr_ch_e42", ch, 3'b000);
    step(3);  chk("sr_wait_e45", st, 1);

    // Lock chattering with period 6 while waiting for lock
    for (int i = 0; i < 4; i++) begin
      pll_lock = 1'b0; step(3);
      pll_lock = 1'b1; step(3);
    end
    step(6);  chk("tg_ch_hold", ch, 3'b000);
              chk("tg_st_wait", st, 1);
              chk("tg_llc", llc, 1);
    step(1);  chk("tg_ch_rel", ch, 3'b001);
    step(6);  chk("tg_ch_run", ch, 3'b111);
              chk("tg_done", done, 1);

    // Short request glitch is filtered
    rst_req_n = 1'b0; step(2);
    rst_req_n = 1'b1; step(8);
    chk("gl_ch", ch, 3'b111);
    chk("gl_st", st, 3);

    // Six-cycle request: debounced, aborts after deb falls
    rst_req_n = 1'b0;
    step(6);  rst_req_n = 1'b1;
              chk("rq_ch_g6", ch, 3'b111);
    step(1);  chk("rq_ch_g7", ch, 3'b000);
              chk("rq_st_g7", st, 0);
              chk("rq_llc_g7", llc, 1);

    // NCH=1 instance
    reset1 = 1'b0;
    step(14); chk("n1_ch_e14", ch1, 1'b0);
              chk("n1_done_e14", done1, 0);
    step(1);  chk("n1_ch_e15", ch1, 1'b1);
              chk("n1_done_e15", done1, 1);
              chk("n1_st_e15", st1, 3);
    for (int i = 0; i < 300; i++) begin
      pll_lock1 = 1'b0;
      step(1); pll_lock1 = 1'b1;
      step(2);
      chk("n1_abort_ch", ch1, 1'b0);
      chk("n1_llc", llc1, (i + 1 > 255) ? 255 : i + 1);
      step(12);
      chk("n1_pre_done", done1, 0);
      step(1);
      chk("n1_ch_rel", ch1, 1'b1);
      chk("n1_done_rel", done1, 1);
    end
    chk("n1_llc_sat", llc1, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
